// File: rtl/rr_sel_arbiter4_pkg.sv
// rr_sel_arbiter4_pkg
// Shared definitions for the round-robin mux-select arbiter:
//   NUM_CH  - number of request channels / mux inputs
//   SEL_W   - width of the mux select
//   state_t - arbiter FSM states (ST_IDLE, ST_SERVE)
//   onehot  - select index to one-hot grant vector
package rr_sel_arbiter4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter4_pick.sv
// rr_pick4
// Combinational round-robin picker. The search starts at last+1 and wraps,
// so the channel granted most recently has the lowest priority.
// Ports:
//   req  [3:0] in  - per-channel request
//   last [1:0] in  - most recently granted channel
//   pick [1:0] out - chosen channel (meaningful only when any=1)
//   any        out - at least one request is active
module rr_pick4
  import rr_sel_arbiter4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);

  logic [SEL_W-1:0] cand;
  logic             found;

  // Walk the four candidates in rotated order; the 2-bit add wraps mod 4,
  // and the last step (k=4) lands back on 'last' itself.
  always_comb begin
    pick  = last;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4
// Round-robin sequencer driving the select of a downstream 4:1 mux. Each
// grant is held for dwell+1 cycles; all outputs are registered so the mux
// select never glitches.
// Ports:
//   clk               in  - system clock, rising edge
//   rst_n             in  - asynchronous active-low reset
//   en                in  - arbitration enable (gates new grants only)
//   req   [3:0]       in  - per-channel request, bit i = mux input i
//   dwell [DWELL_W-1:0] in - slot length minus one, sampled at grant
//   sel   [1:0]       out - mux select (current or most recent grant)
//   grant [3:0]       out - one-hot grant, 0000 when idle
//   valid             out - a slot is active
//   slot_end          out - final cycle of the current slot
module rr_sel_arbiter4
  import rr_sel_arbiter4_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_CH-1:0]  req,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_CH-1:0]  grant,
  output logic               valid,
  output logic               slot_end
);

  state_t             state, state_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0]   last, last_nx;
  logic [SEL_W-1:0]   sel_nx;
  logic [NUM_CH-1:0]  grant_nx;
  logic               valid_nx;
  logic [SEL_W-1:0]   pick_base;
  logic [SEL_W-1:0]   pick;
  logic               any;

  // A back-to-back re-pick at the end of a slot must already see the
  // updated 'last' (which becomes sel on that same edge), so in SERVE the
  // picker is fed sel directly. In IDLE 'last' already holds that value.
  assign pick_base = (state == ST_SERVE) ? sel : last;

  rr_pick4 u_pick (
    .req  (req),
    .last (pick_base),
    .pick (pick),
    .any  (any)
  );

  // Decoded from registered state only.
  assign slot_end = valid && (cnt == '0);

  // State and output registers; reset aborts any slot and restores last=3
  // so the first search after reset starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= SEL_W'(NUM_CH - 1);
      sel   <= '0;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
      sel   <= sel_nx;
      grant <= grant_nx;
      valid <= valid_nx;
    end
  end

  // Next-state logic. A slot always runs to completion; en and req are only
  // looked at when a new grant could be issued.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    sel_nx   = sel;
    grant_nx = grant;
    valid_nx = valid;
    case (state)
      ST_IDLE: begin
        if (en && any) begin
          sel_nx   = pick;
          grant_nx = onehot(pick);
          valid_nx = 1'b1;
          cnt_nx   = dwell;
          state_nx = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - DWELL_W'(1);
        end else begin
          last_nx = sel;
          if (en && any) begin
            sel_nx   = pick;
            grant_nx = onehot(pick);
            valid_nx = 1'b1;
            cnt_nx   = dwell;
          end else begin
            state_nx = ST_IDLE;
            valid_nx = 1'b0;
            grant_nx = '0;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        valid_nx = 1'b0;
        grant_nx = '0;
      end
    endcase
  end

endmodule

// File: doc/rr_sel_arbiter4.md
Name: rr_sel_arbiter4

Overview:
Round-robin channel sequencer that drives the 2-bit select of the downstream 4:1 mux, so the mux time-shares four request lines onto one output. It arbitrates among active requests and holds each grant for a programmable dwell time. It also publishes a one-hot grant and slot framing for consumers of the mux output. Outputs are registered, so the mux select is glitch-free.

Parameters:
DWELL_W, 4, width of the dwell counter; a slot lasts dwell+1 cycles (1..2^DWELL_W).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; gates new grants only
req  input  4  per-channel request, bit i = mux input i
dwell  input  DWELL_W  slot length minus one; sampled when a grant is issued
sel  output  2  select to downstream mux; index of the granted or most recently granted channel
grant  output  4  one-hot grant of the current slot; 0000 when idle
valid  output  1  1 while a slot is active; mux output is meaningful
slot_end  output  1  1 on the final cycle of the current slot

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=00, grant=0000, valid=0, slot_end=0, cnt=0, last=3 (so the first search starts at ch0). Outputs clear immediately, without waiting for a clock edge.
- Round-robin pick: search from last+1, then last+2, last+3, last (mod 4); take the first i with req[i]=1. The last-granted channel therefore has the lowest priority.
- States: IDLE, SERVE.
- IDLE: if en=1 and |req at a rising edge, then on that edge:
  - load sel=pick, grant=onehot(pick), valid=1, cnt=dwell;
  - go to SERVE.
  - Latency: grant is visible in the cycle after the edge that samples req.
  - Otherwise stay in IDLE; sel holds its value.
- SERVE: cnt decrements each edge while cnt!=0. slot_end = valid && (cnt==0), decoded from registered state only. At the edge where cnt==0:
  - last<=sel.
  - If en=1 and |req: re-pick using the updated last. The next slot starts back-to-back with no idle cycle, and cnt reloads from dwell.
  - Else: go to IDLE, valid=0, grant=0000, sel holds.
- The slot always runs to completion. Dropping req[sel] or en mid-slot does not shorten it. dwell changes mid-slot have no effect.
- dwell=0 gives one-cycle slots; slot_end=1 on every valid cycle.
- A single persistent requester is re-granted back-to-back; valid stays 1.
- Requests from all four channels are served fairly: each is served once per 4 slots.
- Simultaneous events:
  - req changing on the slot_end edge: the value sampled on that edge is used.
  - en falling on that edge: no new grant.
- Reset mid-slot: the slot is aborted and last=3 is restored.

Decomposition:
- Shared include/package: NUM_CH=4, SEL_W=2, state encodings ST_IDLE/ST_SERVE.
- Sub-module rr_pick4 (combinational):
  - inputs: req[3:0], last[1:0];
  - outputs: pick[1:0], any.
  - It holds the rotate/priority logic and is unit-testable on its own.
- The top level holds the FSM, counter and output registers.

Test Plan:
1. rst_n=0 with random req/en -> sel=00, grant=0000, valid=0, slot_end=0 asynchronously; after release with req=0000, stays IDLE.
2. en=1, req=1111, dwell=0 -> sel sequence 0,1,2,3,0,1 on consecutive cycles; grant 0001,0010,0100,1000; valid and slot_end continuously 1.
3. req=1010, dwell=2 -> ch1 for 3 cycles (slot_end on the 3rd), then ch3 for 3 cycles, then ch1. valid never drops; the first grant appears 1 cycle after req is sampled.
4. req=0100, dwell=1 -> ch2 re-granted back-to-back. Clear req mid-slot -> the slot still runs 2 cycles, then valid=0, grant=0000, sel holds 10.
5. req=1111, dwell=3, drop en in the 2nd cycle of the ch0 slot -> ch0 completes 4 cycles, then IDLE. Re-raise en -> next grant is ch1.
6. dwell=5, ch0 slot in progress, assert rst_n=0 mid-cycle -> outputs clear before the next edge. Release with req=1111 -> first grant is ch0. Changing dwell mid-slot leaves the slot length unchanged.
